// File: rtl/univ_shift_reg_n.sv
// Universal N-bit shift register with multi-cycle shift/rotate engine.
// Commands handshake on cmd_valid/cmd_ready; done pulses once per command.
module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROTR  = 3'b100;
  localparam logic [2:0] M_ROTL  = 3'b101;
  localparam logic [2:0] M_ASHR  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] data_n;
  logic [WIDTH-1:0] stepped;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] sat;
  logic [2:0]       mode_q, mode_n;
  logic             done_n;

  assign sat = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

  // One-bit step of the latched operation; fill bits are taken live.
  always_comb begin
    stepped = data_out;
    unique case (mode_q)
      M_SHR:   stepped = {serial_in_r, data_out[WIDTH-1:1]};
      M_SHL:   stepped = {data_out[WIDTH-2:0], serial_in_l};
      M_ROTR:  stepped = {data_out[0], data_out[WIDTH-1:1]};
      M_ROTL:  stepped = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
      M_ASHR:  stepped = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
      default: stepped = data_out;
    endcase
  end

  always_comb begin
    state_n = state;
    data_n  = data_out;
    cnt_n   = cnt;
    mode_n  = mode_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          unique case (mode)
            M_HOLD: done_n = 1'b1;
            M_LOAD: begin
              data_n = data_in;
              done_n = 1'b1;
            end
            M_CLEAR: begin
              data_n = '0;
              done_n = 1'b1;
            end
            default: begin
              if (amount == '0) begin
                done_n = 1'b1;
              end else begin
                cnt_n   = sat;
                mode_n  = mode;
                state_n = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          data_n = stepped;
          cnt_n  = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      data_out <= '0;
      cnt      <= '0;
      mode_q   <= M_HOLD;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      data_out <= data_n;
      cnt      <= cnt_n;
      mode_q   <= mode_n;
      done     <= done_n;
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state == SHIFT);
  assign serial_out_r = data_out[0];
  assign serial_out_l = data_out[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n: directed scenarios then randomized commands
// checked against an arithmetic model of multi-step shifts and rotates.
module tb_univ_shift_reg_n;

  localparam int W = 8;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROTR  = 3'b100;
  localparam logic [2:0] M_ROTL  = 3'b101;
  localparam logic [2:0] M_ASHR  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  logic         clock;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   mode;
  logic [3:0]   amount;
  logic [W-1:0] data_in;
  logic         serial_in_r;
  logic         serial_in_l;
  logic         abort;
  logic [W-1:0] data_out;
  logic         serial_out_r;
  logic         serial_out_l;
  logic         busy;
  logic         done;

  int           vectors;
  int           miscompares;
  logic [W-1:0] cur;

  univ_shift_reg_n #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .mode(mode),
    .amount(amount),
    .data_in(data_in),
    .serial_in_r(serial_in_r),
    .serial_in_l(serial_in_l),
    .abort(abort),
    .data_out(data_out),
    .serial_out_r(serial_out_r),
    .serial_out_l(serial_out_l),
    .busy(busy),
    .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Value after k steps of operation m from v, with constant fill bits.
  function automatic logic [W-1:0] model(
    input logic [W-1:0] v,
    input logic [2:0]   m,
    input int           k,
    input bit           fr,
    input bit           fl
  );
    int u;
    int s;
    int r;
    u = int'(v);
    r = u;
    case (m)
      M_SHR:  r = (u >> k) | (fr ? ((255 << (W - k)) & 255) : 0);
      M_SHL:  r = ((u << k) & 255) | (fl ? ((1 << k) - 1) : 0);
      M_ROTR: r = ((u >> k) | (u << (W - k))) & 255;
      M_ROTL: r = ((u << k) | (u >> (W - k))) & 255;
      M_ASHR: begin
        s = v[W-1] ? u - 256 : u;
        r = (s >>> k) & 255;
      end
      default: r = u;
    endcase
    return r[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    abort = 1'($urandom % 2);
    @(posedge clock);
    #1;
    abort = 1'b0;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", cmd_ready, 1);
    check("idle_data", data_out, cur);
  endtask

  // cut_at: index of the shift edge that gets abort/reset instead of a step.
  task automatic do_cmd(
    input logic [2:0]   m,
    input logic [3:0]   amt,
    input logic [W-1:0] din,
    input bit           fr,
    input bit           fl,
    input int           cut_at,
    input bit           cut_rst,
    input bit           noise
  );
    int           steps;
    logic [W-1:0] start;
    check("pre_ready", cmd_ready, 1);
    cmd_valid   = 1'b1;
    mode        = m;
    amount      = amt;
    data_in     = din;
    serial_in_r = fr;
    serial_in_l = fl;
    steps = 0;
    if (m inside {M_SHR, M_SHL, M_ROTR, M_ROTL, M_ASHR})
      steps = (amt > 8) ? 8 : int'(amt);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    if (steps == 0) begin
      if (m == M_LOAD) cur = din;
      if (m == M_CLEAR) cur = '0;
      check("single_data", data_out, cur);
      check("single_done", done, 1);
      check("single_busy", busy, 0);
      check("single_ready", cmd_ready, 1);
      return;
    end
    start = cur;
    for (int k = 0; k < steps; k++) begin
      check("step_busy", busy, 1);
      check("step_done", done, 0);
      check("step_ready", cmd_ready, 0);
      check("step_data", data_out, model(start, m, k, fr, fl));
      if (noise) begin
        cmd_valid = 1'($urandom % 2);
        mode      = 3'($urandom);
        amount    = 4'($urandom);
        data_in   = W'($urandom);
      end
      if (k == cut_at) begin
        if (cut_rst) reset = 1'b1;
        else abort = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        cur = cut_rst ? '0 : model(start, m, k, fr, fl);
        check("cut_data", data_out, cur);
        check("cut_busy", busy, 0);
        check("cut_done", done, 0);
        check("cut_ready", cmd_ready, 1);
        return;
      end
      @(posedge clock);
      #1;
    end
    cmd_valid = 1'b0;
    cur = model(start, m, steps, fr, fl);
    check("fin_data", data_out, cur);
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    check("fin_ready", cmd_ready, 1);
    check("fin_sor", serial_out_r, cur[0]);
    check("fin_sol", serial_out_l, cur[W-1]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cur         = '0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    mode        = M_HOLD;
    amount      = '0;
    data_in     = '0;
    serial_in_r = 1'b0;
    serial_in_l = 1'b0;
    abort       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_data", data_out, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);

    do_cmd(M_LOAD, 4'd0, 8'hA5, 0, 0, -1, 0, 0);
    check("load_val", data_out, 8'hA5);
    idle_cycle();

    do_cmd(M_ROTR, 4'd3, 8'h00, 0, 0, -1, 0, 0);
    check("rotr_val", data_out, 8'hB4);
    do_cmd(M_ROTL, 4'd3, 8'h00, 0, 0, -1, 0, 0);
    check("rotl_val", data_out, 8'hA5);
    idle_cycle();

    do_cmd(M_LOAD, 4'd0, 8'h90, 0, 0, -1, 0, 0);
    do_cmd(M_ASHR, 4'd2, 8'h00, 0, 0, -1, 0, 0);
    check("ashr_val", data_out, 8'hE4);
    check("ashr_sor", serial_out_r, 0);
    idle_cycle();

    do_cmd(M_CLEAR, 4'd0, 8'h5A, 0, 0, -1, 0, 0);
    do_cmd(M_SHL, 4'd12, 8'h00, 0, 1, -1, 0, 0);
    check("sat_val", data_out, 8'hFF);
    do_cmd(M_SHR, 4'd0, 8'h00, 1, 0, -1, 0, 0);
    check("shr0_val", data_out, 8'hFF);
    idle_cycle();

    do_cmd(M_LOAD, 4'd0, 8'hFF, 0, 0, -1, 0, 0);
    do_cmd(M_SHR, 4'd5, 8'h00, 0, 0, 2, 0, 0);
    check("abort_val", data_out, 8'h3F);
    idle_cycle();
    do_cmd(M_LOAD, 4'd0, 8'hFF, 0, 0, -1, 0, 0);
    do_cmd(M_SHR, 4'd5, 8'h00, 0, 0, 2, 1, 0);
    check("rstcut_val", data_out, 8'h00);
    idle_cycle();

    for (int i = 0; i < 60; i++) begin
      do_cmd(3'($urandom), 4'($urandom), W'($urandom),
             1'($urandom), 1'($urandom),
             ($urandom % 4 == 0) ? int'($urandom % 8) : -1,
             ($urandom % 5 == 0), 1);
      if ($urandom % 2 == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_n.md
UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

Interface
REQ-001 Parameters SHALL be:
  - WIDTH, default 8, register width in bits (legal values >= 2).
  - CNT_W, default $clog2(WIDTH)+1, width of the shift-amount field.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clock  in  1  rising-edge clock.
  - reset  in  1  synchronous, active-high reset.
  - cmd_valid  in  1  command request.
  - cmd_ready  out  1  block accepts a command.
  - mode  in  3  operation code.
  - amount  in  CNT_W  shift count for shift/rotate modes.
  - data_in  in  WIDTH  parallel load data.
  - serial_in_r  in  1  fill bit entering the MSB on a logical right shift.
  - serial_in_l  in  1  fill bit entering the LSB on a left shift.
  - abort  in  1  terminates an in-progress shift.
  - data_out  out  WIDTH  register contents.
  - serial_out_r  out  1  equals data_out[0].
  - serial_out_l  out  1  equals data_out[WIDTH-1].
  - busy  out  1  high while in the SHIFT state.
  - done  out  1  one-cycle command-completion pulse.
REQ-003 Reset is reset, synchronous, active-high; the clock is clock.

Function
REQ-004 mode encoding SHALL be:
  - 000 HOLD
  - 001 SHR: logical right shift, MSB filled from serial_in_r.
  - 010 SHL: left shift, LSB filled from serial_in_l.
  - 011 LOAD
  - 100 ROTR
  - 101 ROTL
  - 110 ASHR: right shift with MSB replicated.
  - 111 CLEAR
REQ-005 The FSM SHALL have two states, IDLE and SHIFT. cmd_ready=1 only in IDLE; busy=1 only in SHIFT.
REQ-006 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1. cmd_valid while busy SHALL be ignored, with no queuing.
REQ-007 Single-edge commands (HOLD, LOAD, CLEAR, and any shift/rotate mode with amount=0):
  - On the accepting edge: LOAD sets data_out=data_in, CLEAR sets data_out=0, HOLD and amount=0 leave data_out unchanged.
  - done=1 for exactly the following cycle.
  - The FSM stays in IDLE.
REQ-008 A shift/rotate command with amount=n>=1 SHALL load the step counter with min(n, WIDTH) and enter SHIFT.
  - data_out is not modified on the accepting edge.
REQ-009 In SHIFT, each rising edge SHALL perform exactly one 1-bit step of the latched mode and decrement the counter.
  - mode and amount are latched at acceptance.
  - serial_in_r / serial_in_l are sampled live at each step edge.
REQ-010 On the step edge that brings the counter to 0, the FSM SHALL return to IDLE and done SHALL be 1 for the following cycle.
  - Total busy cycles = min(n, WIDTH).
REQ-011 amount > WIDTH SHALL saturate to WIDTH steps.
  - ROTR/ROTL by WIDTH restores the original value.
  - SHR/SHL by WIDTH yields the fill bit replicated across all bits.
REQ-012 abort=1 in SHIFT SHALL return the FSM to IDLE on that edge with no step performed.
  - data_out keeps its partial value; done stays 0.
  - abort in IDLE has no effect.
REQ-013 cmd_ready SHALL be 1 in the cycle after the final step or after an abort, so back-to-back commands are legal.
REQ-014 done SHALL never be asserted for two consecutive cycles from one command. A new command accepted while done=1 is legal.
REQ-015 serial_out_r and serial_out_l SHALL be combinational views of data_out.

Reset
REQ-016 While reset=1 at a rising edge:
  - data_out=0, state=IDLE, counter=0.
  - done=0, busy=0, cmd_ready=1 after that edge.
REQ-017 reset SHALL take priority over abort, cmd_valid and any in-progress shift; a shift cut by reset produces no done.

Verification (WIDTH=8)
REQ-018 The bench SHALL cover the following scenarios:
  - Reset: assert reset 2 cycles -> data_out=0x00, busy=0, done=0, cmd_ready=1.
  - LOAD: data_in=0xA5 -> data_out=0xA5 after the accepting edge; done high one cycle; busy never high.
  - Rotate: from 0xA5, ROTR amount=3 -> data_out steps 0xD2, 0x69, 0xB4; busy exactly 3 cycles; done one cycle after the third step; back-to-back ROTL amount=3 -> 0xA5.
  - Arithmetic shift: from 0x90, ASHR amount=2 -> 0xC8 then 0xE4; serial_out_r=0 at completion.
  - Saturation: from 0x00, SHL amount=12 with serial_in_l=1 -> busy exactly 8 cycles, final 0xFF; SHR amount=0 -> no change, done next cycle.
  - Abort/reset: from 0xFF, SHR amount=5, serial_in_r=0, abort after 2 steps -> data_out=0x3F, done never pulses, cmd_ready=1 next cycle; repeat with reset instead of abort -> data_out=0x00, no done.
